// File: rtl/fpga_top.sv
// fpga_top: single-port synchronous RAM, SIZE words x DATA_WIDTH bits.
// Read-first on same-address read-during-write, registered read data on q.
// scan_mode=1 freezes both the array and the output register(s).
// Optional feature macro: FPGA_TOP_OUTREG_EN adds a second output register,
// which makes the read latency two clocks.
// Handshake: none. addr/data/we are sampled on every rising clk edge
// while scan_mode=0 and global_resetn=1. There is no valid/ready pairing.
module fpga_top #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 1024
) (
  input  logic                  clk,
  input  logic                  global_resetn,
  input  logic                  scan_en,
  input  logic                  scan_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q
);

  // The address space must map one-to-one onto the array (no aliasing).
  if (SIZE != (2 ** ADDR_WIDTH)) begin : g_size_check
    $error("fpga_top: SIZE must equal 2**ADDR_WIDTH");
  end

  // scan_en is reserved and has no functional effect.
  logic w_unused;
  assign w_unused = scan_en;

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [DATA_WIDTH-1:0] r_q;
  logic                  w_active;
  logic                  w_wr;

  // Normal operation only outside reset and outside scan freeze.
  assign w_active = global_resetn & ~scan_mode;
  assign w_wr     = w_active & we;

  // Array write. The array has no reset, so it maps onto block RAM. The
  // whole word is written in one edge, so a reset landing mid-write
  // leaves the word either old or new, never partially written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[addr] <= data;
    end
  end

  // First read stage. The non-blocking write above makes a same-address
  // read return the pre-write word (read-first).
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_q <= '0;
    end else if (!scan_mode) begin
      r_q <= r_mem[addr];
    end
  end

`ifdef FPGA_TOP_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_q2;

  // Second output stage. Reset and scan freeze behave as in stage one.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      r_q2 <= '0;
    end else if (!scan_mode) begin
      r_q2 <= r_q;
    end
  end

  assign q = r_q2;
`else
  assign q = r_q;
`endif

endmodule

// File: tb/tb_fpga_top.sv
// Directed and table-driven bench for fpga_top with the default one-clock
// read latency.
module tb_fpga_top;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          global_resetn;
  logic          scan_en;
  logic          scan_mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we;
  logic [DW-1:0] q;

  int total;
  int bad;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [1024];

  typedef struct {
    logic          we;
    logic          scan;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          chk;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  fpga_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(1024)) dut (
    .clk           (clk),
    .global_resetn (global_resetn),
    .scan_en       (scan_en),
    .scan_mode     (scan_mode),
    .addr          (addr),
    .data          (data),
    .we            (we),
    .q             (q)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare: one FAIL line per mismatch
  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance through one active edge and return on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: present one cycle of inputs (called on a falling edge)
  task automatic drive(input logic w, input logic s, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    we        = w;
    scan_mode = s;
    addr      = a;
    data      = d;
    scan_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic add(input logic w, input logic s, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic c,
                     input logic [DW-1:0] e, input string n);
    vec_t v;
    v.we = w; v.scan = s; v.addr = a; v.data = d;
    v.chk = c; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    global_resetn = 1'b0;
    drive(1'b1, 1'b0, 10'h281, 32'hFFFF_FFFF);

    // Reset held for ten cycles with a write attempt: q stays 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_hold_q", q, '0);
    end
    global_resetn = 1'b1;
    drive(1'b0, 1'b0, 10'h281, '0);
    #1 check("after_release_q", q, '0);

    // Directed table: expected q is the word read at that edge
    add(1, 0, 10'h281, 32'h1215_3524, 0, '0,            "wr_281");
    add(0, 0, 10'h281, '0,            1, 32'h1215_3524, "rd_281");
    add(1, 0, 10'h005, 32'hA5A5_A5A5, 0, '0,            "wr5_init");
    add(1, 0, 10'h005, 32'h0000_000A, 1, 32'hA5A5_A5A5, "rdw5_old");
    add(1, 0, 10'h005, 32'h0000_000B, 1, 32'h0000_000A, "rdw5_a");
    add(0, 0, 10'h005, '0,            1, 32'h0000_000B, "rd5_b");
    add(1, 0, 10'h000, 32'h0000_0001, 0, '0,            "wr_000");
    add(1, 0, 10'h3FF, 32'h8000_0000, 0, '0,            "wr_3ff");
    add(1, 0, 10'h200, 32'h2222_2222, 0, '0,            "wr_200");
    add(0, 0, 10'h000, '0,            1, 32'h0000_0001, "rd_000_noalias");
    add(0, 0, 10'h3FF, '0,            1, 32'h8000_0000, "rd_3ff");
    add(0, 0, 10'h200, '0,            1, 32'h2222_2222, "rd_200");
    add(1, 0, 10'h003, 32'hDEAD_BEEF, 0, '0,            "wr_003");
    add(0, 0, 10'h003, '0,            1, 32'hDEAD_BEEF, "rd_003");
    add(1, 1, 10'h003, 32'h0000_0000, 1, 32'hDEAD_BEEF, "scan_wr_blocked");
    add(0, 1, 10'h281, '0,            1, 32'hDEAD_BEEF, "scan_q_frozen");
    add(0, 0, 10'h003, '0,            1, 32'hDEAD_BEEF, "rd_003_after_scan");
    add(0, 0, 10'h281, '0,            1, 32'h1215_3524, "rd_281_again");

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].scan, vecs[i].addr, vecs[i].data);
      step();
      if (vecs[i].chk) check(vecs[i].name, q, vecs[i].exp);
    end

    // Asynchronous reset between edges, with write attempts during reset
    drive(1'b0, 1'b0, 10'h003, '0);
    step();
    check("pre_async_rd_003", q, 32'hDEAD_BEEF);
    #2 global_resetn = 1'b0;
    #1 check("async_clear_q", q, '0);
    @(negedge clk);
    drive(1'b1, 1'b0, 10'h003, 32'h0000_0000);
    for (int i = 0; i < 2; i++) begin
      step();
      check("in_reset_q", q, '0);
    end
    global_resetn = 1'b1;
    drive(1'b0, 1'b0, 10'h003, '0);
    #1 check("post_release_q", q, '0);
    step();
    check("rd_003_after_reset", q, 32'hDEAD_BEEF);

    // Random write-then-read against a model array
    for (int i = 0; i < 1024; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 1023));
      d = $urandom;
      model[a] = d;
      drive(1'b1, 1'b0, a, d);
      step();
      exp_q.push_back(model[a]);
      drive(1'b0, 1'b0, a, '0);
      step();
      check("rand_wr_rd", q, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
